// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multi-digit 7-segment scanner with tear-free shadow, blink, LZ suppression and brightness PWM
module seg7_scan_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 8192,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [5*NUM_DIGITS-1:0] i_glyphs,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    input  logic                    i_lz_en,
    input  logic [2:0]              i_bright,
    input  logic                    i_load,
    output logic                    o_load_ack,
    output logic                    o_frame,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   seg_sel
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int PW = CW + 3;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] WIN = PW'(SCAN_DIV - BLANK_CYC);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic [4:0]            sh_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic                  cnt_wrap, idx_wrap, fcnt_wrap, boundary;
    logic [NUM_DIGITS-1:0] sup;
    logic                  run;
    logic [PW-1:0]         on_len, pos;
    logic                  lit;
    logic [7:0]            data_d;
    logic [NUM_DIGITS-1:0] sel_d;

    function automatic logic [7:0] decode(input logic [4:0] g);
        case (g)
            5'h00: decode = 8'hFC;
            5'h01: decode = 8'h60;
            5'h02: decode = 8'hDA;
            5'h03: decode = 8'hF2;
            5'h04: decode = 8'h66;
            5'h05: decode = 8'hB6;
            5'h06: decode = 8'hBE;
            5'h07: decode = 8'hE0;
            5'h08: decode = 8'hFE;
            5'h09: decode = 8'hF6;
            5'h0A: decode = 8'hEE;
            5'h0B: decode = 8'h3E;
            5'h0C: decode = 8'h9C;
            5'h0D: decode = 8'h7A;
            5'h0F: decode = 8'h8E;
            5'h10: decode = 8'h00;
            5'h11: decode = 8'h02;
            5'h12: decode = 8'h1E;
            default: decode = 8'h9E;
        endcase
    endfunction

    assign cnt_wrap  = cnt == CW'(SCAN_DIV - 1);
    assign idx_wrap  = idx == IW'(NUM_DIGITS - 1);
    assign fcnt_wrap = fcnt == FW'(BLINK_FRAMES - 1);
    assign boundary  = cnt == '0 && idx == '0;

    // Zero or blank glyphs from the top extend the suppressed run; digit 0 always shows
    always_comb begin
        sup = '0;
        run = i_lz_en;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run    = run && (sh_glyph[k] == 5'h00 || sh_glyph[k] == 5'h10);
            sup[k] = run;
        end
    end

    always_comb begin
        on_len = (WIN * (PW'(i_bright) + PW'(1))) >> 3;
        pos    = PW'(cnt) - PW'(BLANK_CYC);
        lit    = i_en && PW'(cnt) >= PW'(BLANK_CYC) && pos < on_len
                 && !(phase && i_blink[idx]) && !(sup[idx] && !sh_dp[idx]);
        data_d = lit ? ((sup[idx] ? 8'h00 : decode(sh_glyph[idx])) | {7'b0, sh_dp[idx]}) : 8'h00;
        sel_d  = lit ? NUM_DIGITS'(1) << idx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            sh_glyph   <= '{default: 5'h10};
            sh_dp      <= '0;
            seg_data   <= '0;
            seg_sel    <= '0;
            o_frame    <= 1'b0;
            o_load_ack <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap)
                idx <= idx_wrap ? '0 : idx + 1'b1;
            if (cnt_wrap && idx_wrap) begin
                fcnt <= fcnt_wrap ? '0 : fcnt + 1'b1;
                if (fcnt_wrap)
                    phase <= ~phase;
            end
            o_frame    <= boundary;
            o_load_ack <= boundary && i_load;
            if (boundary && i_load) begin
                for (int k = 0; k < NUM_DIGITS; k++)
                    sh_glyph[k] <= i_glyphs[5*k +: 5];
                sh_dp <= i_dp;
            end
            seg_data <= data_d;
            seg_sel  <= sel_d;
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed + randomized checks against a time-indexed reference model
module tb_seg7_scan_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [19:0] glyphs = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        lz = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic        load = 1'b0;
    logic        load_ack, frame;
    logic [7:0]  seg_data;
    logic [3:0]  seg_sel;

    int tests = 0;
    int fails = 0;
    int t = 0;
    logic [4:0] sh_g [4] = '{5'h10, 5'h10, 5'h10, 5'h10};
    logic [3:0] sh_dp = '0;
    logic [7:0] tab [32] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E,
                             8'h00, 8'h02, 8'h1E, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E,
                             8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E};

    seg7_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_glyphs(glyphs), .i_dp(dp), .i_blink(blink),
        .i_lz_en(lz), .i_bright(bright), .i_load(load), .o_load_ack(load_ack),
        .o_frame(frame), .seg_data(seg_data), .seg_sel(seg_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    // Model: t counts cycles since reset release; slot, digit, frame and blink phase follow arithmetically
    task automatic step();
        int c, d, ph, on;
        logic [3:0] sup;
        logic lead, lit, ef, ea;
        logic [7:0] ed;
        logic [3:0] es;
        c    = t % 16;
        d    = (t / 16) % 4;
        ph   = (t / 128) % 2;
        on   = (14 * (int'(bright) + 1)) / 8;
        lead = 1'b1;
        sup  = '0;
        for (int k = 3; k > 0; k--) begin
            lead   = lead && (sh_g[k] == 5'h00 || sh_g[k] == 5'h10);
            sup[k] = lead && lz;
        end
        lit = en && c >= 2 && (c - 2) < on && !(ph == 1 && blink[d]) && !(sup[d] && !sh_dp[d]);
        ed  = lit ? ((sup[d] ? 8'h00 : tab[sh_g[d]]) | {7'b0, sh_dp[d]}) : 8'h00;
        es  = lit ? 4'(1 << d) : 4'h0;
        ef  = !rst && (t % 64 == 0);
        ea  = ef && load;
        if (rst) begin
            ed = '0;
            es = '0;
        end
        @(posedge clk);
        if (rst) begin
            t = 0;
            for (int k = 0; k < 4; k++) sh_g[k] = 5'h10;
            sh_dp = '0;
        end else begin
            if (t % 64 == 0 && load) begin
                for (int k = 0; k < 4; k++) sh_g[k] = glyphs[5*k +: 5];
                sh_dp = dp;
            end
            t++;
        end
        #1;
        chk("seg_data", seg_data, ed);
        chk("seg_sel", {4'h0, seg_sel}, {4'h0, es});
        chk("o_frame", {7'b0, frame}, {7'b0, ef});
        chk("o_load_ack", {7'b0, load_ack}, {7'b0, ea});
    endtask

    initial begin
        load   = 1'b1;
        glyphs = {5'd4, 5'd3, 5'd2, 5'd1};
        repeat (3) step();
        rst = 1'b0;
        repeat (70) step();
        bright = 3'd3;
        repeat (64) step();
        lz     = 1'b1;
        glyphs = {5'd0, 5'd0, 5'd5, 5'd0};
        repeat (128) step();
        lz     = 1'b0;
        bright = 3'd7;
        blink  = 4'b0100;
        repeat (400) step();
        blink = 4'b0000;
        while (t % 64 != 10) step();
        glyphs = {5'h11, 5'h12, 5'h0E, 5'h1F};
        dp     = 4'b1010;
        while (t % 64 != 50) step();
        load = 1'b0;
        repeat (80) step();
        load = 1'b1;
        en   = 1'b0;
        repeat (40) step();
        en = 1'b1;
        repeat (40) step();
        for (int r = 0; r < 50; r++) begin
            for (int k = 0; k < 4; k++) glyphs[5*k +: 5] = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom % 32);
            dp     = 4'($urandom);
            blink  = 4'($urandom);
            bright = 3'($urandom);
            lz     = 1'($urandom);
            en     = ($urandom % 8) != 0;
            load   = 1'($urandom);
            repeat ($urandom_range(1, 60)) step();
        end
        en     = 1'b1;
        blink  = '0;
        lz     = 1'b0;
        dp     = '0;
        bright = 3'd7;
        load   = 1'b0;
        for (int i = 0; i < 64 && t % 64 != 37; i++) step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        glyphs = {5'h15, 5'h15, 5'h15, 5'h15};
        repeat (150) step();
        load = 1'b1;
        repeat (70) step();
        load = 1'b0;
        repeat (64) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
